// File: rtl/rx_mac_lite_meta_merge_pkg.sv
// Shared types and widths for the RX MAC Lite metadata merge block.
// Single region; all widths are derived from the block geometry below.
package rx_mac_lite_meta_pkg;

   localparam int REGION_SIZE   = 8;
   localparam int BLOCK_SIZE    = 8;
   localparam int ITEM_WIDTH    = 8;
   localparam int META_WIDTH    = 64;
   localparam int FIFO_DEPTH    = 16;
   localparam int DATA_WIDTH    = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
   localparam int SOF_POS_WIDTH = $clog2(REGION_SIZE);
   localparam int EOF_POS_WIDTH = $clog2(REGION_SIZE * BLOCK_SIZE);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    data;
      logic [SOF_POS_WIDTH-1:0] sof_pos;
      logic [EOF_POS_WIDTH-1:0] eof_pos;
      logic                     sof;
      logic                     eof;
   } mfb_word_t;

   typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} fsm_state_t;

   // True when the EOF in a word belongs to the frame started by that word's SOF.
   function automatic logic eof_after_sof(input logic [SOF_POS_WIDTH-1:0] sof_pos,
                                          input logic [EOF_POS_WIDTH-1:0] eof_pos);
      return (int'(eof_pos) >= int'(sof_pos) * BLOCK_SIZE);
   endfunction

endpackage

// File: rtl/rx_mac_lite_meta_merge_if.sv
// MFB frame-stream and MVB metadata-stream interfaces used by the merge block.
interface rx_mac_lite_mfb_if;
   import rx_mac_lite_meta_pkg::*;

   mfb_word_t word;
   logic      src_rdy;
   logic      dst_rdy;

   modport master (output word, output src_rdy, input dst_rdy);
   modport slave  (input word, input src_rdy, output dst_rdy);
endinterface

interface rx_mac_lite_mvb_if;
   import rx_mac_lite_meta_pkg::*;

   logic [META_WIDTH-1:0] data;
   logic                  vld;
   logic                  src_rdy;
   logic                  dst_rdy;

   modport master (output data, output vld, output src_rdy, input dst_rdy);
   modport slave  (input data, input vld, input src_rdy, output dst_rdy);
endinterface

// File: rtl/rx_mac_lite_meta_merge_meta_fifo.sv
// Synchronous metadata FIFO with registered full/empty flags and no push-to-pop bypass.
module meta_fifo
   import rx_mac_lite_meta_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = META_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [AW:0]      count_next_s;
   logic             full_r;
   logic             empty_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign push_ok_s = push & ~full_r;
   assign pop_ok_s  = pop & ~empty_r;

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_next_s = count_r;
      if (push_ok_s && !pop_ok_s) begin
         count_next_s = count_r + (AW+1)'(1);
      end else if (!push_ok_s && pop_ok_s) begin
         count_next_s = count_r - (AW+1)'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointers, occupancy and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r <= count_next_s;
         full_r  <= (count_next_s == (AW+1)'(DEPTH));
         empty_r <= (count_next_s == (AW+1)'(0));
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign pop_data = mem_r[rd_ptr_r];
   assign full     = full_r;
   assign empty    = empty_r;

endmodule

// File: rtl/rx_mac_lite_meta_merge.sv
// Re-emits the RX MAC Lite MFB stream one cycle late with the buffered MVB item
// attached to every EOF word; also flags framing protocol errors.
module rx_mac_lite_meta_merge
   import rx_mac_lite_meta_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   rx_mac_lite_mfb_if.slave       rx_mfb,
   rx_mac_lite_mvb_if.slave       rx_mvb,
   rx_mac_lite_mfb_if.master      tx_mfb,
   output logic [META_WIDTH-1:0]  tx_meta,
   output logic                   proto_err
);

   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   logic [META_WIDTH-1:0]    fifo_head_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     out_free_s;
   logic                     rx_dst_rdy_s;
   logic                     accept_s;

   logic                     tx_src_rdy_r;
   logic                     tx_sof_r;
   logic                     tx_eof_r;
   logic [DATA_WIDTH-1:0]    tx_data_r;
   logic [SOF_POS_WIDTH-1:0] tx_sof_pos_r;
   logic [EOF_POS_WIDTH-1:0] tx_eof_pos_r;
   logic [META_WIDTH-1:0]    tx_meta_r;
   fsm_state_t               state_r;
   logic                     proto_err_r;

   assign push_s = rx_mvb.src_rdy & rx_mvb.vld & ~fifo_full_s;
   assign rx_mvb.dst_rdy = ~fifo_full_s;

   meta_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(META_WIDTH)) u_meta_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (rx_mvb.data),
      .pop       (pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // An EOF word waits for its metadata; other words only wait for the output slot.
   assign out_free_s   = ~tx_src_rdy_r | tx_mfb.dst_rdy;
   assign rx_dst_rdy_s = out_free_s & (~(rx_mfb.src_rdy & rx_mfb.word.eof) | ~fifo_empty_s);
   assign rx_mfb.dst_rdy = rx_dst_rdy_s;
   assign accept_s = rx_mfb.src_rdy & rx_dst_rdy_s;
   assign pop_s    = accept_s & rx_mfb.word.eof;

   // Output valid and framing flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_src_rdy_r <= 1'b0;
         tx_sof_r     <= 1'b0;
         tx_eof_r     <= 1'b0;
      end else if (accept_s) begin
         tx_src_rdy_r <= 1'b1;
         tx_sof_r     <= rx_mfb.word.sof;
         tx_eof_r     <= rx_mfb.word.eof;
      end else if (tx_mfb.dst_rdy) begin
         tx_src_rdy_r <= 1'b0;
         tx_sof_r     <= 1'b0;
         tx_eof_r     <= 1'b0;
      end
   end

   // Output payload and metadata
   always_ff @(posedge clk) begin
      if (accept_s) begin
         tx_data_r    <= rx_mfb.word.data;
         tx_sof_pos_r <= rx_mfb.word.sof_pos;
         tx_eof_pos_r <= rx_mfb.word.eof_pos;
      end
      if (pop_s) tx_meta_r <= fifo_head_s;
   end

   // Framing tracker: flags SOF inside a frame and EOF outside one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         proto_err_r <= 1'b0;
      end else if (accept_s) begin
         case (state_r)
            IDLE: begin
               if (rx_mfb.word.sof && !rx_mfb.word.eof) begin
                  state_r <= FRAME;
               end else if (rx_mfb.word.sof && rx_mfb.word.eof) begin
                  if (!eof_after_sof(rx_mfb.word.sof_pos, rx_mfb.word.eof_pos)) begin
                     proto_err_r <= 1'b1;
                     state_r     <= FRAME;
                  end
               end else if (rx_mfb.word.eof) begin
                  proto_err_r <= 1'b1;
               end
            end
            FRAME: begin
               if (rx_mfb.word.eof && !rx_mfb.word.sof) begin
                  state_r <= IDLE;
               end else if (rx_mfb.word.sof && rx_mfb.word.eof) begin
                  if (eof_after_sof(rx_mfb.word.sof_pos, rx_mfb.word.eof_pos)) begin
                     proto_err_r <= 1'b1;
                     state_r     <= IDLE;
                  end
               end else if (rx_mfb.word.sof) begin
                  proto_err_r <= 1'b1;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign tx_mfb.word = '{data: tx_data_r, sof_pos: tx_sof_pos_r, eof_pos: tx_eof_pos_r,
                          sof: tx_sof_r, eof: tx_eof_r};
   assign tx_mfb.src_rdy = tx_src_rdy_r;
   assign tx_meta        = tx_meta_r;
   assign proto_err      = proto_err_r;

endmodule

// File: tb/tb_rx_mac_lite_meta_merge.sv
// Directed bench for rx_mac_lite_meta_merge with a scoreboarded random-backpressure phase.
module tb_rx_mac_lite_meta_merge;
   import rx_mac_lite_meta_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic [META_WIDTH-1:0] tx_meta;
   logic proto_err;

   int vectors = 0;
   int miscompares = 0;
   int sent = 0;
   int rcvd = 0;
   bit drv_done = 1'b0;
   mfb_word_t exp_word_q[$];
   logic [META_WIDTH-1:0] exp_meta_q[$];

   rx_mac_lite_mfb_if rx_mfb ();
   rx_mac_lite_mvb_if rx_mvb ();
   rx_mac_lite_mfb_if tx_mfb ();

   rx_mac_lite_meta_merge dut (
      .clk       (clk),
      .rst       (rst),
      .rx_mfb    (rx_mfb),
      .rx_mvb    (rx_mvb),
      .tx_mfb    (tx_mfb),
      .tx_meta   (tx_meta),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] pat(input int a, input int b);
      return {16{a[15:0], b[15:0]}};
   endfunction

   task automatic drive(input logic sof, input logic eof, input logic [2:0] sp,
                        input logic [5:0] ep, input logic [511:0] d);
      rx_mfb.word.sof     = sof;
      rx_mfb.word.eof     = eof;
      rx_mfb.word.sof_pos = sp;
      rx_mfb.word.eof_pos = ep;
      rx_mfb.word.data    = d;
      rx_mfb.src_rdy      = 1'b1;
   endtask

   task automatic idle_mfb();
      rx_mfb.src_rdy  = 1'b0;
      rx_mfb.word.sof = 1'b0;
      rx_mfb.word.eof = 1'b0;
   endtask

   task automatic mvb(input logic en, input logic [63:0] d);
      rx_mvb.src_rdy = en;
      rx_mvb.vld     = en;
      rx_mvb.data    = d;
   endtask

   initial begin
      rst = 1'b1;
      tx_mfb.dst_rdy = 1'b1;
      idle_mfb();
      rx_mfb.word.data = '0;
      rx_mfb.word.sof_pos = '0;
      rx_mfb.word.eof_pos = '0;
      mvb(1'b0, 64'h0);

      // Reset state
      repeat (2) tick();
      chk("rst_tx_src_rdy", tx_mfb.src_rdy, 1'b0);
      chk("rst_tx_sof", tx_mfb.word.sof, 1'b0);
      chk("rst_tx_eof", tx_mfb.word.eof, 1'b0);
      chk("rst_proto_err", proto_err, 1'b0);
      rst = 1'b0;
      tick();
      chk("rst_mvb_dst_rdy", rx_mvb.dst_rdy, 1'b1);

      // 1) metadata first, then a 3-word frame
      mvb(1'b1, 64'hA5);
      tick();
      mvb(1'b0, 64'h0);
      drive(1'b1, 1'b0, 3'd0, 6'd0, pat(1, 0));
      #1 chk("t1_rx_rdy_w0", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t1_w0_src_rdy", tx_mfb.src_rdy, 1'b1);
      chk("t1_w0_sof", tx_mfb.word.sof, 1'b1);
      chk("t1_w0_data", tx_mfb.word.data, pat(1, 0));
      drive(1'b0, 1'b0, 3'd0, 6'd0, pat(1, 1));
      tick();
      chk("t1_w1_data", tx_mfb.word.data, pat(1, 1));
      chk("t1_w1_sof", tx_mfb.word.sof, 1'b0);
      drive(1'b0, 1'b1, 3'd0, 6'd20, pat(1, 2));
      #1 chk("t1_rx_rdy_w2", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t1_w2_eof", tx_mfb.word.eof, 1'b1);
      chk("t1_w2_eof_pos", tx_mfb.word.eof_pos, 6'd20);
      chk("t1_w2_meta", tx_meta, 64'hA5);
      idle_mfb();
      tick();
      chk("t1_drained", tx_mfb.src_rdy, 1'b0);

      // 2) EOF word arrives before its metadata
      drive(1'b1, 1'b0, 3'd0, 6'd0, pat(2, 0));
      tick();
      chk("t2_w0_data", tx_mfb.word.data, pat(2, 0));
      drive(1'b0, 1'b1, 3'd0, 6'd5, pat(2, 1));
      for (int i = 0; i < 10; i++) begin
         #1 chk("t2_stall", rx_mfb.dst_rdy, 1'b0);
         tick();
      end
      chk("t2_no_out", tx_mfb.src_rdy, 1'b0);
      mvb(1'b1, 64'h11);
      #1 chk("t2_push_cycle_rdy", rx_mfb.dst_rdy, 1'b0);
      tick();
      mvb(1'b0, 64'h0);
      #1 chk("t2_released", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t2_eof", tx_mfb.word.eof, 1'b1);
      chk("t2_meta", tx_meta, 64'h11);
      chk("t2_data", tx_mfb.word.data, pat(2, 1));
      idle_mfb();
      tick();

      // 3) fill the FIFO, check full, then pop through it
      for (int i = 1; i <= 16; i++) begin
         mvb(1'b1, 64'(i));
         #1 chk("t3_mvb_rdy", rx_mvb.dst_rdy, 1'b1);
         tick();
      end
      mvb(1'b1, 64'hEE);
      chk("t3_full", rx_mvb.dst_rdy, 1'b0);
      tick();
      chk("t3_still_full", rx_mvb.dst_rdy, 1'b0);
      mvb(1'b0, 64'h0);
      drive(1'b1, 1'b1, 3'd0, 6'd3, pat(3, 1));
      #1 chk("t3_rx_rdy", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t3_meta_1", tx_meta, 64'h1);
      chk("t3_not_full", rx_mvb.dst_rdy, 1'b1);
      for (int k = 2; k <= 16; k++) begin
         drive(1'b1, 1'b1, 3'd0, 6'd3, pat(3, k));
         tick();
         chk("t3_meta_drain", tx_meta, 64'(k));
      end
      drive(1'b1, 1'b1, 3'd0, 6'd3, pat(3, 99));
      #1 chk("t3_empty_after_drain", rx_mfb.dst_rdy, 1'b0);
      idle_mfb();
      tick();

      // 4) EOF of one frame and SOF of the next in the same word
      mvb(1'b1, 64'h1);
      tick();
      mvb(1'b1, 64'h2);
      tick();
      mvb(1'b0, 64'h0);
      drive(1'b1, 1'b0, 3'd0, 6'd0, pat(4, 0));
      tick();
      drive(1'b1, 1'b1, 3'd2, 6'd7, pat(4, 1));
      #1 chk("t4_rx_rdy", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t4_sof", tx_mfb.word.sof, 1'b1);
      chk("t4_eof", tx_mfb.word.eof, 1'b1);
      chk("t4_meta_1", tx_meta, 64'h1);
      drive(1'b0, 1'b1, 3'd0, 6'd9, pat(4, 2));
      tick();
      chk("t4_meta_2", tx_meta, 64'h2);
      chk("t4_proto_err", proto_err, 1'b0);
      idle_mfb();
      tick();

      // 5) 200 frames against random downstream backpressure
      fork
         begin : driver
            int nw;
            bit acc;
            mfb_word_t ew;
            for (int f = 0; f < 200; f++) begin
               mvb(1'b1, {32'hC0DE0000, 32'(f)});
               tick();
               mvb(1'b0, 64'h0);
               nw = $urandom_range(1, 3);
               for (int w = 0; w < nw; w++) begin
                  drive(w == 0, w == nw - 1, 3'd0,
                        (w == nw - 1) ? 6'($urandom_range(0, 63)) : 6'd0, pat(f + 100, w));
                  acc = 1'b0;
                  for (int c = 0; c < 100 && !acc; c++) begin
                     @(negedge clk);
                     #2;
                     acc = rx_mfb.dst_rdy;
                     if (acc) begin
                        ew = rx_mfb.word;
                        exp_word_q.push_back(ew);
                        if (ew.eof) exp_meta_q.push_back({32'hC0DE0000, 32'(f)});
                        sent++;
                     end
                     @(posedge clk);
                     #1;
                  end
                  chk("t5_drv_accept", acc, 1'b1);
               end
               idle_mfb();
            end
            drv_done = 1'b1;
         end
         begin : monitor
            mfb_word_t mw;
            for (int c = 0; c < 20000 && !(drv_done && exp_word_q.size() == 0); c++) begin
               @(negedge clk);
               tx_mfb.dst_rdy = 1'($urandom_range(0, 1));
               #1;
               if (tx_mfb.src_rdy && tx_mfb.dst_rdy) begin
                  rcvd++;
                  chk("t5_word_expected", exp_word_q.size() > 0, 1'b1);
                  if (exp_word_q.size() > 0) begin
                     mw = exp_word_q.pop_front();
                     chk("t5_word", tx_mfb.word, mw);
                     if (mw.eof) chk("t5_meta", tx_meta, exp_meta_q.pop_front());
                  end
               end
            end
         end
      join
      tx_mfb.dst_rdy = 1'b1;
      chk("t5_queue_empty", exp_word_q.size(), 0);
      chk("t5_count", rcvd, sent);
      chk("t5_proto_err", proto_err, 1'b0);
      tick();

      // 6) SOF inside a frame, then reset mid-frame
      drive(1'b1, 1'b0, 3'd0, 6'd0, pat(6, 0));
      tick();
      drive(1'b1, 1'b0, 3'd0, 6'd0, pat(6, 1));
      tick();
      chk("t6_proto_err_set", proto_err, 1'b1);
      drive(1'b0, 1'b0, 3'd0, 6'd0, pat(6, 2));
      tick();
      chk("t6_proto_err_sticky", proto_err, 1'b1);
      mvb(1'b1, 64'h66);
      tick();
      mvb(1'b0, 64'h0);
      rst = 1'b1;
      #1;
      chk("t6_rst_src_rdy", tx_mfb.src_rdy, 1'b0);
      chk("t6_rst_proto_err", proto_err, 1'b0);
      chk("t6_rst_eof", tx_mfb.word.eof, 1'b0);
      tick();
      rst = 1'b0;
      idle_mfb();
      tick();
      chk("t6_mvb_rdy", rx_mvb.dst_rdy, 1'b1);
      drive(1'b0, 1'b1, 3'd0, 6'd4, pat(6, 3));
      #1 chk("t6_fifo_empty", rx_mfb.dst_rdy, 1'b0);
      mvb(1'b1, 64'h77);
      tick();
      mvb(1'b0, 64'h0);
      #1 chk("t6_rx_rdy", rx_mfb.dst_rdy, 1'b1);
      tick();
      chk("t6_meta", tx_meta, 64'h77);
      chk("t6_eof_outside_frame", proto_err, 1'b1);
      idle_mfb();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
